mem_burst_sequencer: RTL and testbench
======================================

// Module: mem_burst_sequencer
// PURPOSE
//  Converts block read/write requests (start address + word count) from the image
//  pipeline into single-word accesses on the mem_manager user port (address/wren/
//  data_write/data_read). It honours the mem_manager pause output and tracks the
//  fixed read latency, returning read words in issue order.
//  Sits directly upstream of mem_manager, in the modified_clock domain.
// PARAMETERS
//  ADDR_WIDTH     18  word address width; matches mem_manager address port
//  DATA_WIDTH     32  data word width
//  READ_LATENCY   2   non-paused cycles from read issue to valid data_read (>=1)
//  LEN_WIDTH      9   width of req_length; maximum burst is 2^LEN_WIDTH-1 words
// PORTS
//  clk              in   1           system clock (modified_clock)
//  reset            in   1           synchronous, active-high
//  controller_ready in   1           mem_manager controller_ready; gates request acceptance
//  pause            in   1           mem_manager pause; freezes all progress while high
//  req_valid        in   1           request present
//  req_ready        out  1           request accepted when req_valid & req_ready
//  req_write        in   1           1 = write burst, 0 = read burst
//  req_address      in   ADDR_WIDTH  first word address
//  req_length       in   LEN_WIDTH   number of words; 0 = no-op
//  wr_data          in   DATA_WIDTH  write stream word
//  wr_data_valid    in   1           write word present
//  wr_data_ready    out  1           write word consumed when valid & ready
//  rd_data          out  DATA_WIDTH  returned read word (registered)
//  rd_data_valid    out  1           rd_data valid, 1-cycle qualifier per word
//  done             out  1           1-cycle pulse at burst completion
//  busy             out  1           high whenever state != IDLE
//  address          out  ADDR_WIDTH  to mem_manager address
//  wren             out  1           to mem_manager wren
//  data_write       out  DATA_WIDTH  to mem_manager data_write
//  data_read        in   DATA_WIDTH  from mem_manager data_read
// BEHAVIOUR
//  - Reset: state IDLE; cur_addr, remaining and latency pipe cleared; outputs rd_data,
//    rd_data_valid, done, busy, wren, address and data_write all 0. Reset mid-burst
//    aborts the burst: no further issue, no rd_data_valid, no done.
//  - FSM states: IDLE, WRITE, READ, DRAIN, DONE.
//  - IDLE: req_ready = controller_ready. On accept, latch cur_addr = req_address and
//    remaining = req_length. Then go to DONE if length == 0, else to WRITE or READ.
//  - Issue cycle: a cycle with pause == 0 and either (WRITE & wr_data_valid) or READ.
//    During an issue cycle, address = cur_addr. On the closing edge, cur_addr increments
//    and remaining decrements. cur_addr wraps modulo 2^ADDR_WIDTH (all-ones -> 0).
//  - WRITE: wr_data_ready = ~pause. wren = ~pause & wr_data_valid (combinational).
//    data_write = wr_data pass-through. A wr_data_valid gap is a bubble (wren 0,
//    no count). After the last issue, go to DONE.
//  - READ: one address is issued every non-paused cycle and wren stays 0. Each issue
//    pushes a tag into a READ_LATENCY-deep shift pipe. After the last issue, go to DRAIN.
//  - Latency pipe: advances only when pause == 0. When its tail is set and pause == 0,
//    rd_data <= data_read and rd_data_valid <= 1 on that edge. Net latency is
//    READ_LATENCY+1 non-paused cycles from issue to rd_data_valid.
//  - DRAIN: wait until the pipe is empty and the final word is captured. done is
//    asserted in the same cycle as the final rd_data_valid; then go to IDLE.
//  - DONE (write or zero-length burst): done = 1 for one cycle; next state is IDLE.
//  - pause high: no issue, wren = 0, address holds, pipe frozen, remaining unchanged.
//  - busy = (state != IDLE). req_ready = 0 whenever busy.
//  - controller_ready is sampled only in IDLE; a drop mid-burst is ignored.
//  - In IDLE, wren = 0 and address holds its last value.
// TESTING
//  1. Write addr 200000, len 3, data 0xA/0xB/0xC, wr_data_valid held high -> wren high
//     3 consecutive cycles at 200000/200001/200002 with matching data_write; done pulses
//     on the next cycle.
//  2. Read addr 200000, len 2, READ_LATENCY 2, model returns addr^0x5A5A -> rd_data_valid
//     3 and 4 cycles after the first issue with the correct words; done coincides with
//     the 2nd rd_data_valid.
//  3. Pause high 2 cycles after the 1st write issue -> wren 0, address holds 200001,
//     wr_data_ready 0; exactly 3 writes in total; done after the 3rd.
//  4. Read addr 262143, len 2 -> addresses issued are 262143 then 0; two rd_data_valid pulses.
//  5. len 0 -> no wren, no rd_data_valid, done 1 cycle after accept. controller_ready 0
//     with req_valid 1 -> req_ready 0 and busy stays 0.
//  6. reset asserted 1 cycle after the first read issue -> next cycle all outputs 0,
//     state IDLE, no rd_data_valid or done afterwards.

Source files
------------

// File: rtl/mem_burst_sequencer.sv
// Burst-to-single-word sequencer for the mem_manager user port.
// Splits block read/write requests into per-word accesses and returns read words in order.
module mem_burst_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 18,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned LEN_WIDTH    = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  controller_ready,
  input  logic                  pause,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [LEN_WIDTH-1:0]  req_length,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wren,
  output logic [DATA_WIDTH-1:0] data_write,
  input  logic [DATA_WIDTH-1:0] data_read
);

  localparam int unsigned PIPE_W = READ_LATENCY;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [PIPE_W-1:0]     pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_rd_q, done_rd_d;

  logic                  issue_wr;
  logic                  issue_rd;
  logic                  issue;
  logic                  last_issue;
  logic [PIPE_W-1:0]     pipe_shift;
  logic                  pipe_tail;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      remaining_q <= '0;
      pipe_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_rd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      last_addr_q <= last_addr_d;
      remaining_q <= remaining_d;
      pipe_q      <= pipe_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_rd_q   <= done_rd_d;
    end
  end

  assign issue_wr   = (state_q == S_WRITE) && !pause && wr_data_valid;
  assign issue_rd   = (state_q == S_READ) && !pause;
  assign issue      = issue_wr || issue_rd;
  assign last_issue = (remaining_q == LEN_WIDTH'(1));
  assign pipe_shift = pipe_q << 1;
  assign pipe_tail  = pipe_q[PIPE_W-1];

  // Next-state, address sequencing and read-latency tracking
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    last_addr_d = last_addr_q;
    remaining_d = remaining_q;
    pipe_d      = pipe_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_rd_d   = 1'b0;

    // The pipe tail lines up with data_read of the matching issue
    if (!pause) begin
      pipe_d = pipe_shift | PIPE_W'(issue_rd);
      if (pipe_tail) begin
        rd_data_d  = data_read;
        rd_valid_d = 1'b1;
      end
    end

    if (issue) begin
      last_addr_d = cur_addr_q;
      cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - LEN_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid && controller_ready) begin
          cur_addr_d  = req_address;
          remaining_d = req_length;
          if (req_length == '0) begin
            state_d = S_DONE;
          end else if (req_write) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        if (issue_wr && last_issue) state_d = S_DONE;
      end
      S_READ: begin
        if (issue_rd && last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pause && pipe_tail && (pipe_shift == '0)) begin
          state_d   = S_IDLE;
          done_rd_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port outputs; write strobe path is combinational so a word is issued in the cycle it is offered
  assign busy          = (state_q != S_IDLE);
  assign req_ready     = (state_q == S_IDLE) && controller_ready;
  assign wr_data_ready = (state_q == S_WRITE) && !pause;
  assign wren          = issue_wr;
  assign data_write    = (state_q == S_WRITE) ? wr_data : '0;
  assign address       = ((state_q == S_WRITE) || (state_q == S_READ)) ? cur_addr_q : last_addr_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign done          = done_rd_q || (state_q == S_DONE);

endmodule

// File: tb/tb_mem_burst_sequencer.sv
// Scoreboard bench for mem_burst_sequencer: directed bursts, expected events queued
// with their cycle offset from request acceptance, checked by an independent monitor.
module tb_mem_burst_sequencer;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam int unsigned RL = 2;
  localparam int unsigned LW = 9;

  localparam int K_WR = 0;
  localparam int K_RD = 1;
  localparam int K_DN = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    int          rel;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          controller_ready;
  logic          pause;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_address;
  logic [LW-1:0] req_length;
  logic [DW-1:0] wr_data;
  logic          wr_data_valid;
  logic          wr_data_ready;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          done;
  logic          busy;
  logic [AW-1:0] address;
  logic          wren;
  logic [DW-1:0] data_write;
  logic [DW-1:0] data_read;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  t0 = 0;

  logic [AW-1:0] mem_d1, mem_d2;

  mem_burst_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset), .controller_ready(controller_ready), .pause(pause),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_length(req_length),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .done(done), .busy(busy),
    .address(address), .wren(wren), .data_write(data_write), .data_read(data_read)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // mem_manager read model: fixed 2-cycle latency, frozen while paused
  always @(posedge clk) begin
    if (!pause) begin
      mem_d1 <= address;
      mem_d2 <= mem_d1;
    end
  end
  assign data_read = 32'(mem_d2) ^ 32'h0000_5A5A;

  function automatic void push(int kind, logic [31:0] a, logic [31:0] d, int rel);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.rel = rel;
    sb.push_back(e);
  endfunction

  function automatic void observe(string nm, int kind, logic [31:0] a, logic [31:0] d);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s unexpected: addr=%0d data=%h rel=%0d", nm, a, d, cyc - t0);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.a != a || e.d != d || e.rel != (cyc - t0)) begin
        n_err++;
        $display("FAIL %s got kind=%0d addr=%0d data=%h rel=%0d want kind=%0d addr=%0d data=%h rel=%0d",
                 nm, kind, a, d, cyc - t0, e.kind, e.a, e.d, e.rel);
      end
    end
  endfunction

  // Monitor: every DUT-presented event must match the scoreboard head
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (wren === 1'b1) observe("write", K_WR, 32'(address), data_write);
      if (rd_data_valid === 1'b1) observe("read", K_RD, 32'h0, rd_data);
      if (done === 1'b1) observe("done", K_DN, 32'h0, 32'h0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic accept(input logic wr, input int addr, input int len);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr;
    req_address = AW'(addr); req_length = LW'(len);
    @(negedge clk);
    chk("req_ready_on_accept", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic drive_writes(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] w[3];
    int idx;
    int guard;
    logic rdy;
    w[0] = w0; w[1] = w1; w[2] = w2;
    idx = 0; guard = 0;
    while (idx < 3 && guard < 50) begin
      wr_data = w[idx];
      wr_data_valid = 1'b1;
      @(negedge clk);
      rdy = wr_data_ready;
      @(posedge clk); #1;
      if (rdy) idx++;
      guard++;
    end
    wr_data_valid = 1'b0;
    if (idx < 3) begin
      n_cmp++; n_err++;
      $display("FAIL write_stream_timeout consumed=%0d want=3", idx);
    end
  endtask

  task automatic end_test(input string nm, input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
    chk(nm, 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  initial begin
    reset = 1'b1; controller_ready = 1'b1; pause = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_length = '0;
    wr_data = '0; wr_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", 32'(rd_data_valid), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wren", 32'(wren), 32'h0);
    chk("rst_address", 32'(address), 32'h0);
    chk("rst_data_write", data_write, 32'h0);
    reset = 1'b0;

    // 1: three-word write, valid held high
    push(K_WR, 32'd200000, 32'hA, 0);
    push(K_WR, 32'd200001, 32'hB, 1);
    push(K_WR, 32'd200002, 32'hC, 2);
    push(K_DN, 32'h0, 32'h0, 3);
    wr_data = 32'hA; wr_data_valid = 1'b1;
    accept(1'b1, 200000, 3);
    drive_writes(32'hA, 32'hB, 32'hC);
    end_test("t1_drained", 6);

    // 2: two-word read, data = addr ^ 0x5A5A
    push(K_RD, 32'h0, 32'h0003_571A, 3);
    push(K_RD, 32'h0, 32'h0003_571B, 4);
    push(K_DN, 32'h0, 32'h0, 4);
    accept(1'b0, 200000, 2);
    end_test("t2_drained", 8);

    // 3: write with a two-cycle pause after the first issue
    push(K_WR, 32'd200000, 32'h11, 0);
    push(K_WR, 32'd200001, 32'h22, 3);
    push(K_WR, 32'd200002, 32'h33, 4);
    push(K_DN, 32'h0, 32'h0, 5);
    wr_data = 32'h11; wr_data_valid = 1'b1;
    accept(1'b1, 200000, 3);
    fork
      drive_writes(32'h11, 32'h22, 32'h33);
      begin
        @(posedge clk); #1;
        pause = 1'b1;
        @(negedge clk);
        chk("t3_pause_wren", 32'(wren), 32'h0);
        chk("t3_pause_address", 32'(address), 32'd200001);
        chk("t3_pause_wr_ready", 32'(wr_data_ready), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pause = 1'b0;
      end
    join
    end_test("t3_drained", 6);

    // 4: read wrapping the top of the address space
    push(K_RD, 32'h0, 32'h0003_A5A5, 3);
    push(K_RD, 32'h0, 32'h0000_5A5A, 4);
    push(K_DN, 32'h0, 32'h0, 4);
    accept(1'b0, 262143, 2);
    end_test("t4_drained", 8);

    // 5: zero-length request, then controller not ready
    push(K_DN, 32'h0, 32'h0, 0);
    accept(1'b0, 1234, 0);
    end_test("t5_drained", 4);
    controller_ready = 1'b0; req_valid = 1'b1; req_length = LW'(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_req_ready_low", 32'(req_ready), 32'h0);
      chk("t5_busy_low", 32'(busy), 32'h0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; controller_ready = 1'b1;
    end_test("t5_no_events", 4);

    // 6: reset one cycle after the first read issue aborts the burst
    accept(1'b0, 1000, 4);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_rd_valid", 32'(rd_data_valid), 32'h0);
    chk("t6_rd_data", rd_data, 32'h0);
    chk("t6_done", 32'(done), 32'h0);
    chk("t6_wren", 32'(wren), 32'h0);
    chk("t6_address", 32'(address), 32'h0);
    chk("t6_data_write", data_write, 32'h0);
    end_test("t6_no_events", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
